// File: rtl/zk_glyph_blitter.sv
// 16x16 glyph blitter: walks font ROM rows and writes one 16-bit framebuffer word per row.
// Optional ZK_INVERT_EN adds req_inv for inverse-video rendering.
module zk_glyph_blitter #(
  parameter int FB_COLS = 40,
  parameter int FB_ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_code,
  input  logic [5:0]  req_col,
  input  logic [4:0]  req_row,
`ifdef ZK_INVERT_EN
  input  logic        req_inv,
`endif
  output logic [11:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic [14:0] fb_addr,
  output logic [15:0] fb_wdata,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  localparam logic [5:0]  COLS_L  = 6'(FB_COLS);
  localparam logic [4:0]  ROWS_L  = 5'(FB_ROWS);
  localparam logic [14:0] COLS_15 = 15'(FB_COLS);

  state_t      state, nxt;
  logic [3:0]  r;
  logic [5:0]  col_q;
  logic [4:0]  row_q;
  logic        accept, in_range;
  logic [14:0] line_addr;
`ifdef ZK_INVERT_EN
  logic        inv_q;
`endif

  assign accept    = (state == IDLE) && req_valid && req_ready;
  assign in_range  = (req_col < COLS_L) && (req_row < ROWS_L);
  // scan line = row*16 + r, then one word per 16 pixels across the line
  assign line_addr = 15'({row_q, r}) * COLS_15 + 15'(col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept && in_range) nxt = FETCH;
      FETCH:   nxt = WRITE;
      WRITE:   if (fb_ready) nxt = (r == 4'd15) ? IDLE : FETCH;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rom_addr  <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      r         <= '0;
      col_q     <= '0;
      row_q     <= '0;
`ifdef ZK_INVERT_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= (nxt == IDLE);
      case (state)
        IDLE: if (accept) begin
          if (!in_range) err <= 1'b1;
          else begin
            col_q    <= req_col;
            row_q    <= req_row;
            r        <= '0;
            rom_addr <= {req_code, 4'd0};
`ifdef ZK_INVERT_EN
            inv_q    <= req_inv;
`endif
          end
        end
        FETCH: begin
`ifdef ZK_INVERT_EN
          fb_wdata <= inv_q ? ~rom_data : rom_data;
`else
          fb_wdata <= rom_data;
`endif
          fb_addr  <= line_addr;
          fb_we    <= 1'b1;
        end
        WRITE: if (fb_ready) begin
          fb_we <= 1'b0;
          // r stops at 15, so the low nibble never carries into the glyph field
          if (r == 4'd15) done <= 1'b1;
          else begin
            r        <= r + 4'd1;
            rom_addr <= rom_addr + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
